core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/gpu_pkg.sv | 16 +
 rtl/core_scheduler_if.sv | 35 +++
 rtl/core_scheduler_active_thread_pc_mux.sv | 20 ++
 rtl/core_scheduler.sv | 113 +++++++++++
 tb/tb_core_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: core sequencing state encodings.
// The PC units key on EXECUTE and UPDATE from this enum, so the encodings are fixed.
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;

endpackage

// File: rtl/core_scheduler_if.sv
// Handshake bundle between the core scheduler and its surroundings.
// The master side launches blocks and feeds fetch/decode/LSU/PC status.
// The slave side is the scheduler itself.
interface core_scheduler_if #(
  parameter int THREADS               = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
);

  logic                                     start;
  logic [THREADS-1:0]                       thread_enable;
  logic                                     fetch_req;
  logic                                     fetch_done;
  logic                                     decoded_mem_read_enable;
  logic                                     decoded_mem_write_enable;
  logic                                     decoded_ret;
  logic [THREADS-1:0]                       lsu_busy;
  logic [THREADS*PROGRAM_MEM_ADDR_BITS-1:0] next_pc;
  logic [2:0]                               core_state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]         current_pc;
  logic                                     done;
  logic                                     diverged;

  modport master (
    output start, thread_enable, fetch_done, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_busy, next_pc,
    input  fetch_req, core_state, current_pc, done, diverged
  );

  modport slave (
    input  start, thread_enable, fetch_done, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_busy, next_pc,
    output fetch_req, core_state, current_pc, done, diverged
  );

endinterface

// File: rtl/core_scheduler_active_thread_pc_mux.sv
// Picks the next_pc of the lowest-index enabled thread.
// When no thread is enabled the output is zero; the scheduler never consumes it then.
module active_thread_pc_mux #(
  parameter int THREADS               = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic [THREADS-1:0]                       thread_enable,
  input  logic [THREADS*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]         sel_pc
);

  // Scan from the highest index down so the lowest enabled thread wins.
  always_comb begin
    sel_pc = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (thread_enable[i]) sel_pc = next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS];
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Core scheduler: sequences one instruction at a time through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for all enabled threads in lockstep.
// Optional feature macro: CORE_SCHEDULER_DIVERGENCE_CHECK_EN -- when defined,
// thread PCs are compared in UPDATE and any disagreement ends the block.
// The decoded memory enables are carried on the bus for the PC/LSU side; the
// stall decision only needs the per-thread lsu_busy mask.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS               = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input logic             clk,
  input logic             reset,
  core_scheduler_if.slave bus
);

  localparam int W = PROGRAM_MEM_ADDR_BITS;

  localparam logic [2:0] ST_IDLE    = 3'(IDLE);
  localparam logic [2:0] ST_FETCH   = 3'(FETCH);
  localparam logic [2:0] ST_DECODE  = 3'(DECODE);
  localparam logic [2:0] ST_REQUEST = 3'(REQUEST);
  localparam logic [2:0] ST_WAIT    = 3'(WAIT);
  localparam logic [2:0] ST_EXECUTE = 3'(EXECUTE);
  localparam logic [2:0] ST_UPDATE  = 3'(UPDATE);
  localparam logic [2:0] ST_DONE    = 3'(DONE);

  logic [2:0]   state;
  logic [W-1:0] pc;
  logic         done_q;
  logic [W-1:0] sel_pc;
  logic         mismatch;
  logic         lsu_clear;

  active_thread_pc_mux #(
    .THREADS              (THREADS),
    .PROGRAM_MEM_ADDR_BITS(W)
  ) u_pc_mux (
    .thread_enable(bus.thread_enable),
    .next_pc      (bus.next_pc),
    .sel_pc       (sel_pc)
  );

  assign lsu_clear = ((bus.lsu_busy & bus.thread_enable) == '0);

`ifdef CORE_SCHEDULER_DIVERGENCE_CHECK_EN
  logic diverged_q;

  // Flag any enabled thread whose next PC differs from the broadcast choice.
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (bus.thread_enable[i] && (bus.next_pc[i*W +: W] != sel_pc)) mismatch = 1'b1;
    end
  end

  // Divergence is sticky until reset; RET takes priority over the check.
  always_ff @(posedge clk) begin
    if (reset) diverged_q <= 1'b0;
    else if (state == ST_UPDATE && !bus.decoded_ret && mismatch) diverged_q <= 1'b1;
  end

  assign bus.diverged = diverged_q;
`else
  assign mismatch     = 1'b0;
  assign bus.diverged = 1'b0;
`endif

  // Main sequencing FSM with the shared PC and sticky done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (|bus.thread_enable) begin
              state <= ST_FETCH;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_FETCH:   if (bus.fetch_done) state <= ST_DECODE;
        ST_DECODE:  state <= ST_REQUEST;
        ST_REQUEST: state <= ST_WAIT;
        ST_WAIT:    if (lsu_clear) state <= ST_EXECUTE;
        ST_EXECUTE: state <= ST_UPDATE;
        ST_UPDATE: begin
          if (bus.decoded_ret || mismatch) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            pc    <= sel_pc;
            state <= ST_FETCH;
          end
        end
        ST_DONE:    state <= ST_DONE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fetch_req  = (state == ST_FETCH);
  assign bus.core_state = state;
  assign bus.current_pc = pc;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed self-checking bench for core_scheduler.
// Expected values are hand-computed; the divergence scenario follows
// CORE_SCHEDULER_DIVERGENCE_CHECK_EN as built.
module tb_core_scheduler;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  core_scheduler_if #(.THREADS(4), .PROGRAM_MEM_ADDR_BITS(8)) bus ();

  core_scheduler #(
    .THREADS              (4),
    .PROGRAM_MEM_ADDR_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] expected_state);
    tick();
    check_output(tag, 32'(bus.core_state), 32'(expected_state));
  endtask

  // From FETCH with fetch_done asserted, walk one instruction up to UPDATE.
  task automatic run_to_update(input string tag);
    bus.fetch_done = 1'b1;
    step({tag, "_decode"}, 3'd2);
    bus.fetch_done = 1'b0;
    step({tag, "_request"}, 3'd3);
    step({tag, "_wait"}, 3'd4);
    step({tag, "_execute"}, 3'd5);
    step({tag, "_update"}, 3'd6);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors                      = 0;
    miscompares                  = 0;
    reset                        = 1'b1;
    bus.start                    = 1'b0;
    bus.thread_enable            = 4'b0000;
    bus.fetch_done               = 1'b0;
    bus.decoded_mem_read_enable  = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    bus.decoded_ret              = 1'b0;
    bus.lsu_busy                 = 4'b0000;
    bus.next_pc                  = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    check_output("rst_state", 32'(bus.core_state), 32'd0);
    check_output("rst_pc", 32'(bus.current_pc), 32'h00);
    check_output("rst_done", 32'(bus.done), 32'd0);
    check_output("rst_diverged", 32'(bus.diverged), 32'd0);
    check_output("rst_fetch_req", 32'(bus.fetch_req), 32'd0);

    // Non-memory instruction, fetch_done two cycles after fetch_req.
    bus.thread_enable = 4'b1111;
    bus.next_pc       = {8'h05, 8'h05, 8'h05, 8'h05};
    bus.start         = 1'b1;
    step("a_fetch", 3'd1);
    bus.start = 1'b0;
    check_output("a_fetch_req", 32'(bus.fetch_req), 32'd1);
    step("a_fetch_hold1", 3'd1);
    step("a_fetch_hold2", 3'd1);
    run_to_update("a");
    check_output("a_fetch_req_low", 32'(bus.fetch_req), 32'd0);
    check_output("a_pc_before", 32'(bus.current_pc), 32'h00);
    step("a_back_fetch", 3'd1);
    check_output("a_pc_after", 32'(bus.current_pc), 32'h05);

    // RET: block ends, PC holds, later start ignored.
    bus.next_pc = {8'h33, 8'h33, 8'h33, 8'h33};
    bus.fetch_done = 1'b1;
    step("c_decode", 3'd2);
    bus.fetch_done = 1'b0;
    step("c_request", 3'd3);
    step("c_wait", 3'd4);
    step("c_execute", 3'd5);
    bus.decoded_ret = 1'b1;
    step("c_update", 3'd6);
    step("c_done", 3'd7);
    bus.decoded_ret = 1'b0;
    check_output("c_done_flag", 32'(bus.done), 32'd1);
    check_output("c_pc_held", 32'(bus.current_pc), 32'h05);
    bus.start = 1'b1;
    step("c_start_ignored", 3'd7);
    bus.start = 1'b0;
    check_output("c_pc_still", 32'(bus.current_pc), 32'h05);

    // LSU stall on an enabled thread for five WAIT cycles.
    apply_reset();
    bus.thread_enable           = 4'b1111;
    bus.next_pc                 = {8'h06, 8'h06, 8'h06, 8'h06};
    bus.decoded_mem_read_enable = 1'b1;
    bus.start                   = 1'b1;
    step("b_fetch", 3'd1);
    bus.start      = 1'b0;
    bus.fetch_done = 1'b1;
    step("b_decode", 3'd2);
    bus.fetch_done = 1'b0;
    step("b_request", 3'd3);
    bus.lsu_busy = 4'b0100;
    step("b_wait1", 3'd4);
    for (int i = 0; i < 4; i++) step("b_wait_stall", 3'd4);
    bus.lsu_busy = 4'b0000;
    step("b_execute", 3'd5);
    step("b_update", 3'd6);
    step("b_fetch2", 3'd1);
    check_output("b_pc", 32'(bus.current_pc), 32'h06);

    // Busy bit on a disabled thread must not stall.
    apply_reset();
    bus.thread_enable = 4'b0111;
    bus.next_pc       = {8'hEE, 8'h07, 8'h07, 8'h07};
    bus.lsu_busy      = 4'b1000;
    bus.start         = 1'b1;
    step("b2_fetch", 3'd1);
    bus.start = 1'b0;
    run_to_update("b2");
    step("b2_fetch2", 3'd1);
    check_output("b2_pc", 32'(bus.current_pc), 32'h07);
    bus.lsu_busy                = 4'b0000;
    bus.decoded_mem_read_enable = 1'b0;

    // Partial mask: thread 2 drives the PC, then wraps FF -> 00.
    apply_reset();
    bus.thread_enable = 4'b1100;
    bus.next_pc       = {8'hFF, 8'hFF, 8'h22, 8'h11};
    bus.start         = 1'b1;
    step("d_fetch", 3'd1);
    bus.start = 1'b0;
    run_to_update("d");
    step("d_fetch2", 3'd1);
    check_output("d_pc_ff", 32'(bus.current_pc), 32'hFF);
    bus.next_pc = {8'h00, 8'h00, 8'h22, 8'h11};
    run_to_update("d2");
    step("d2_fetch", 3'd1);
    check_output("d_pc_wrap", 32'(bus.current_pc), 32'h00);

    // Thread 1 disagrees with the others.
    apply_reset();
    bus.thread_enable = 4'b1111;
    bus.next_pc       = {8'h07, 8'h07, 8'h09, 8'h07};
    bus.start         = 1'b1;
    step("e_fetch", 3'd1);
    bus.start = 1'b0;
    run_to_update("e");
`ifdef CORE_SCHEDULER_DIVERGENCE_CHECK_EN
    step("e_done", 3'd7);
    check_output("e_diverged", 32'(bus.diverged), 32'd1);
    check_output("e_done_flag", 32'(bus.done), 32'd1);
    check_output("e_pc_held", 32'(bus.current_pc), 32'h00);
`else
    step("e_fetch2", 3'd1);
    check_output("e_diverged", 32'(bus.diverged), 32'd0);
    check_output("e_done_flag", 32'(bus.done), 32'd0);
    check_output("e_pc", 32'(bus.current_pc), 32'h07);
`endif

    // Reset in WAIT after the PC has moved, then start with an empty mask.
    apply_reset();
    bus.thread_enable = 4'b1111;
    bus.next_pc       = {8'h42, 8'h42, 8'h42, 8'h42};
    bus.start         = 1'b1;
    step("f_fetch", 3'd1);
    bus.start = 1'b0;
    run_to_update("f");
    step("f_fetch2", 3'd1);
    check_output("f_pc", 32'(bus.current_pc), 32'h42);
    bus.lsu_busy   = 4'b0001;
    bus.fetch_done = 1'b1;
    step("f_decode", 3'd2);
    bus.fetch_done = 1'b0;
    step("f_request", 3'd3);
    step("f_wait", 3'd4);
    step("f_wait_stall", 3'd4);
    reset = 1'b1;
    step("f_reset_idle", 3'd0);
    reset        = 1'b0;
    bus.lsu_busy = 4'b0000;
    check_output("f_reset_pc", 32'(bus.current_pc), 32'h00);
    check_output("f_reset_done", 32'(bus.done), 32'd0);
    check_output("f_reset_fetch_req", 32'(bus.fetch_req), 32'd0);
    bus.thread_enable = 4'b0000;
    bus.start         = 1'b1;
    step("f_empty_done", 3'd7);
    bus.start = 1'b0;
    check_output("f_empty_done_flag", 32'(bus.done), 32'd1);
    check_output("f_empty_fetch_req", 32'(bus.fetch_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
